// File: rtl/mct_rd_issuer.sv
// AXI4 read-address issuer: splits one contiguous read into fixed-length bursts,
// limits in-flight bursts, and pulses ctrl_done once all bursts have returned.
module mct_rd_issuer #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_DATA_WIDTH      = 512,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_BURST_LEN       = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                         ctrl_done,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                   m_axi_arlen,
  input  logic                         m_axi_rvalid,
  input  logic                         m_axi_rready,
  input  logic                         m_axi_rlast
);

  localparam int XW             = C_XFER_SIZE_WIDTH;
  localparam int LP_BYTES       = C_DATA_WIDTH / 8;
  localparam int LP_LOG_B       = $clog2(LP_BYTES);
  localparam int LP_BURST_BYTES = C_BURST_LEN * LP_BYTES;
  localparam int LP_LOG_ALIGN   = $clog2(LP_BURST_BYTES);
  localparam int LP_OW          = $clog2(C_MAX_OUTSTANDING + 1);

  localparam logic [C_ADDR_WIDTH-1:0] LP_ALIGN_MASK =
    ~((C_ADDR_WIDTH'(1) << LP_LOG_ALIGN) - C_ADDR_WIDTH'(1));
  localparam logic [C_ADDR_WIDTH-1:0] LP_ADDR_STEP = C_ADDR_WIDTH'(LP_BURST_BYTES);
  localparam logic [XW-1:0]           LP_BL        = XW'(C_BURST_LEN);
  localparam logic [XW-1:0]           LP_BEAT_MASK = XW'(LP_BYTES - 1);
  localparam logic [LP_OW-1:0]        LP_MAX_OUT   = LP_OW'(C_MAX_OUTSTANDING);
  localparam logic [7:0]              LP_FULL_LEN  = 8'(C_BURST_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              r_state;
  logic [C_ADDR_WIDTH-1:0] r_araddr;
  logic [XW-1:0]           r_remaining;
  logic [7:0]              r_last_len;
  logic [LP_OW-1:0]        r_outstanding;

  logic [XW-1:0] w_beats;
  logic [XW-1:0] w_tail;
  logic [XW-1:0] w_bursts;
  logic [7:0]    w_last_len;
  logic          w_ar_hs;
  logic          w_r_done;

  // Ceil divisions done as shift/divide plus a remainder bit so sizes near 2^XW cannot overflow.
  always_comb begin
    w_beats    = (ctrl_xfer_size_in_bytes >> LP_LOG_B)
               + XW'(|(ctrl_xfer_size_in_bytes & LP_BEAT_MASK));
    w_tail     = w_beats % LP_BL;
    w_bursts   = (w_beats / LP_BL) + XW'(w_tail != '0);
    w_last_len = (w_tail == '0) ? LP_FULL_LEN : 8'(w_tail - XW'(1));
  end

  assign m_axi_arvalid = (r_state == S_ISSUE) && (r_remaining != '0)
                       && (r_outstanding < LP_MAX_OUT);
  assign w_ar_hs       = m_axi_arvalid && m_axi_arready;
  assign w_r_done      = m_axi_rvalid && m_axi_rready && m_axi_rlast && (r_outstanding != '0);
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arlen   = (r_state != S_ISSUE) ? 8'd0 :
                         (r_remaining == XW'(1)) ? r_last_len : LP_FULL_LEN;
  assign ctrl_done     = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_araddr    <= '0;
      r_remaining <= '0;
      r_last_len  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ctrl_start) begin
            r_araddr    <= ctrl_addr_offset & LP_ALIGN_MASK;
            r_remaining <= w_bursts;
            r_last_len  <= w_last_len;
            r_state     <= (w_bursts == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_ar_hs) begin
            r_araddr    <= r_araddr + LP_ADDR_STEP;
            r_remaining <= r_remaining - XW'(1);
            if (r_remaining == XW'(1)) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_outstanding == '0) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A simultaneous issue and return leaves the count unchanged; a return at zero is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else begin
      case ({w_ar_hs, w_r_done})
        2'b10:   r_outstanding <= r_outstanding + LP_OW'(1);
        2'b01:   r_outstanding <= r_outstanding - LP_OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

endmodule
